// File: rtl/seq_detector_param_if.sv
// Bundles the stream, configuration and status signals of seq_detector_param.
// With SEQDET_STICKY_EN defined the bundle also carries the sticky 'seen' flag.
interface seq_detector_param_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
);
    logic             in;
    logic             in_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic             overlap;
    logic             clear;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;
`ifdef SEQDET_STICKY_EN
    logic             seen;

    modport master (
        output in, in_valid, cfg_load, pattern, pat_len, overlap, clear,
        input  out, match_cnt, armed, seen
    );
    modport slave (
        input  in, in_valid, cfg_load, pattern, pat_len, overlap, clear,
        output out, match_cnt, armed, seen
    );
`else
    modport master (
        output in, in_valid, cfg_load, pattern, pat_len, overlap, clear,
        input  out, match_cnt, armed
    );
    modport slave (
        input  in, in_valid, cfg_load, pattern, pat_len, overlap, clear,
        output out, match_cnt, armed
    );
`endif
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with saturating match counter.
// Optional sticky 'seen' flag is enabled by defining SEQDET_STICKY_EN.
module seq_detector_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rstn,
    seq_detector_param_if.slave bus
);

    typedef enum logic [1:0] {DISARMED, HUNT, COMPARE} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             ovl_q, ovl_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SEQDET_STICKY_EN
    logic             seen_q, seen_d;
`endif

    logic [PAT_W-1:0] hist_n;
    logic [LEN_W-1:0] fill_n;
    logic [LEN_W-1:0] len_clamped;
    logic [PAT_W-1:0] mask;
    logic             match;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        len_d   = len_q;
        fill_d  = fill_q;
        ovl_d   = ovl_q;
        out_d   = 1'b0;
        cnt_d   = cnt_q;
`ifdef SEQDET_STICKY_EN
        seen_d  = seen_q;
`endif
        match   = 1'b0;

        hist_n = {hist_q[PAT_W-2:0], bus.in};
        fill_n = (fill_q < LEN_W'(PAT_W)) ? fill_q + LEN_W'(1) : fill_q;
        len_clamped = (bus.pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.pat_len;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_q));
        end

        // fill counts only bits received since the last restart, so stale history never matches
        if (bus.cfg_load) begin
            pat_d   = bus.pattern;
            len_d   = len_clamped;
            ovl_d   = bus.overlap;
            fill_d  = '0;
            state_d = (len_clamped == '0) ? DISARMED : HUNT;
        end else if (bus.in_valid) begin
            hist_d = hist_n;
            fill_d = fill_n;
            if (state_q != DISARMED) begin
                match = (fill_n >= len_q) && ((hist_n & mask) == (pat_q & mask));
                if (match && !ovl_q) begin
                    fill_d  = '0;
                    state_d = HUNT;
                end else begin
                    state_d = (fill_n >= len_q) ? COMPARE : HUNT;
                end
            end
        end

        if (match) begin
            out_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef SEQDET_STICKY_EN
            seen_d = 1'b1;
`endif
        end

        if (bus.clear) begin
            cnt_d = '0;
`ifdef SEQDET_STICKY_EN
            seen_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= DISARMED;
            hist_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            ovl_q   <= 1'b0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SEQDET_STICKY_EN
            seen_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            ovl_q   <= ovl_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
`ifdef SEQDET_STICKY_EN
            seen_q  <= seen_d;
`endif
        end
    end

    assign bus.out       = out_q;
    assign bus.match_cnt = cnt_q;
    assign bus.armed     = (state_q != DISARMED);
`ifdef SEQDET_STICKY_EN
    assign bus.seen      = seen_q;
`endif

endmodule
